// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-decoder state encoding, command bit layout and
// the CPOL/CPHA edge-select helper used by both slave and master.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StAddr,
    StData
  } spi_state_e;

  localparam int unsigned CMD_RD_BIT = 7;

  // High when MOSI/MISO are sampled on the rising SCLK edge; launch uses the other edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into clk_i and produces single-cycle edge pulses
// for sclk and csn.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic csn_rise_o,
  output logic csn_fall_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] csn_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev_q;
  logic                   csn_prev_q;

  // csn resets low so a chip select already asserted at reset release gives no fall edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q      <= '0;
      csn_q       <= '0;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      csn_q       <= {csn_q[SYNC_STAGES-2:0], csn_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    csn_rise_o  = csn_q[SYNC_STAGES-1] & ~csn_prev_q;
    csn_fall_o  = ~csn_q[SYNC_STAGES-1] & csn_prev_q;
    mosi_o      = mosi_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/spi_slave_regif.sv
// SPI slave that decodes cmd/addr/data frames into single-cycle register bus
// reads and writes; all SPI pins are oversampled in clk_i.
module spi_slave_regif
  import spi_pkg::*;
#(
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  input  logic [7:0] reg_rdata_i,
  output logic       frame_done_o,
  output logic       frame_err_o
);

  localparam logic SampleOnRise = sample_on_rise(CPOL, CPHA);

  logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;
  logic sample_edge, launch_edge;
  logic [7:0] rx_byte;

  spi_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic [6:0] tx_sr_q;
  logic [7:0] tx_buf_q;
  logic [7:0] addr_ptr_q;
  logic       cmd_rd_q;
  logic       rd_pend_q;
  logic       miso_q, miso_oe_q, reg_wr_q, reg_rd_q, done_q, err_q;
  logic [7:0] reg_addr_q, reg_wdata_q;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sclk_i     (spi_clk_i),
    .csn_i      (spi_csn_i),
    .mosi_i     (spi_mosi_i),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall),
    .csn_rise_o (csn_rise),
    .csn_fall_o (csn_fall),
    .mosi_o     (mosi_s)
  );

  always_comb begin
    sample_edge = SampleOnRise ? sclk_rise : sclk_fall;
    launch_edge = SampleOnRise ? sclk_fall : sclk_rise;
    rx_byte     = {rx_sr_q, mosi_s};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      tx_buf_q    <= '0;
      addr_ptr_q  <= '0;
      cmd_rd_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= reg_rd_q;
      if (rd_pend_q) begin
        tx_buf_q <= reg_rdata_i;
      end

      if (state_q == StIdle) begin
        if (csn_fall) begin
          state_q   <= StCmd;
          bit_cnt_q <= '0;
          rx_sr_q   <= '0;
          tx_sr_q   <= '0;
          tx_buf_q  <= '0;
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b1;
        end
      end else if (csn_rise) begin
        // csn rise takes priority over any sample edge seen in the same cycle.
        state_q   <= StIdle;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        done_q    <= (bit_cnt_q == 3'd0);
        err_q     <= (bit_cnt_q != 3'd0);
      end else begin
        if (sample_edge) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          rx_sr_q   <= rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              StCmd: begin
                cmd_rd_q <= rx_byte[CMD_RD_BIT];
                state_q  <= StAddr;
              end
              StAddr: begin
                state_q <= StData;
                if (cmd_rd_q) begin
                  reg_rd_q   <= 1'b1;
                  reg_addr_q <= rx_byte;
                  addr_ptr_q <= rx_byte + 8'd1;
                end else begin
                  addr_ptr_q <= rx_byte;
                end
              end
              StData: begin
                reg_addr_q <= addr_ptr_q;
                addr_ptr_q <= addr_ptr_q + 8'd1;
                if (cmd_rd_q) begin
                  reg_rd_q <= 1'b1;
                end else begin
                  reg_wr_q    <= 1'b1;
                  reg_wdata_q <= rx_byte;
                end
              end
              default: ;
            endcase
          end
        end
        // First launch of each byte takes its MSB straight from tx_buf.
        if (launch_edge) begin
          if (bit_cnt_q == 3'd0) begin
            miso_q  <= tx_buf_q[7];
            tx_sr_q <= tx_buf_q[6:0];
          end else begin
            miso_q  <= tx_sr_q[6];
            tx_sr_q <= {tx_sr_q[5:0], 1'b0};
          end
        end
      end
    end
  end

  always_comb begin
    spi_miso_o    = miso_q;
    spi_miso_oe_o = miso_oe_q;
    reg_wr_o      = reg_wr_q;
    reg_rd_o      = reg_rd_q;
    reg_addr_o    = reg_addr_q;
    reg_wdata_o   = reg_wdata_q;
    frame_done_o  = done_q;
    frame_err_o   = err_q;
  end

endmodule
